// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   sched_state_e : scheduler FSM states
//   req_id_e      : requester identifiers used by the round-robin arbiter
//   *CntW         : counter widths, sized for the full legal parameter ranges
//                   (START_TO 1..15, MAX_RETRY 0..3)
package uart_sched_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StIssue     = 2'd1,
    StWaitStart = 2'd2,
    StWaitDone  = 2'd3
  } sched_state_e;

  typedef enum logic {
    ReqAlu = 1'b0,
    ReqRd  = 1'b1
  } req_id_e;

  localparam int unsigned StartToMax  = 15;
  localparam int unsigned MaxRetryMax = 3;
  localparam int unsigned ToCntW      = $clog2(StartToMax + 1);
  localparam int unsigned RetryCntW   = $clog2(MaxRetryMax + 1);
  localparam int unsigned ByteCntW    = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk, rst         : clock, asynchronous active-low reset
//   en               : grants may only be given while high
//   req_alu, req_rd  : request lines
//   gnt_alu, gnt_rd  : combinational grants, at most one high
// A grant always coincides with its request, so a grant is an acceptance and
// rr_last is updated on it. rr_last resets to RD so the ALU wins first.
module rr_arbiter2
  import uart_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_alu,
  input  logic req_rd,
  output logic gnt_alu,
  output logic gnt_rd
);

  req_id_e rr_last;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_rd  = 1'b0;
    if (en) begin
      if (req_alu && req_rd) begin
        // Contention: the side not served last time wins.
        if (rr_last == ReqRd) begin
          gnt_alu = 1'b1;
        end else begin
          gnt_rd = 1'b1;
        end
      end else begin
        gnt_alu = req_alu;
        gnt_rd  = req_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last <= ReqRd;
    end else if (gnt_alu) begin
      rr_last <= ReqAlu;
    end else if (gnt_rd) begin
      rr_last <= ReqRd;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Sequencer/arbiter in front of a UART transmitter.
//   clk, rst              : clock, asynchronous active-low reset
//   alu_out/valid/ready   : 2*WIDTH-bit ALU result request (sent low byte first)
//   rd_data/valid/ready   : WIDTH-bit register-file byte request
//   tx_busy               : UART busy flag
//   tx_p_data, tx_d_valid : byte and one-cycle Data_Valid pulse to the UART
//   sched_busy            : high whenever the scheduler is not idle
//   tx_err                : one-cycle pulse when a request is dropped after retries
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned START_TO  = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [WIDTH-1:0]   rd_data,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic               tx_busy,
  output logic [WIDTH-1:0]   tx_p_data,
  output logic               tx_d_valid,
  output logic               sched_busy,
  output logic               tx_err
);

  localparam logic [ToCntW-1:0]    ToLimit    = ToCntW'(START_TO);
  localparam logic [RetryCntW-1:0] RetryLimit = RetryCntW'(MAX_RETRY);

  sched_state_e         state;
  logic [WIDTH-1:0]     hold_hi;    // high byte of an accepted ALU word
  logic [ByteCntW-1:0]  bytes_left;
  logic [ToCntW-1:0]    to_cnt;
  logic [RetryCntW-1:0] retry;

  logic grant_en;
  logic gnt_alu;
  logic gnt_rd;

  assign grant_en = (state == StIdle) && !tx_busy;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (grant_en),
    .req_alu (alu_valid),
    .req_rd  (rd_valid),
    .gnt_alu (gnt_alu),
    .gnt_rd  (gnt_rd)
  );

  // Grants only go to a valid requester, so ready doubles as acceptance.
  assign alu_ready  = gnt_alu;
  assign rd_ready   = gnt_rd;
  assign sched_busy = (state != StIdle);

  // tx_d_valid is raised on every transition into StIssue, so it is high
  // exactly for the single cycle spent in StIssue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      hold_hi    <= '0;
      bytes_left <= '0;
      to_cnt     <= '0;
      retry      <= '0;
      tx_p_data  <= '0;
      tx_d_valid <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_d_valid <= 1'b0;
      tx_err     <= 1'b0;
      case (state)
        StIdle: begin
          if (gnt_alu) begin
            hold_hi    <= alu_out[2*WIDTH-1:WIDTH];
            tx_p_data  <= alu_out[WIDTH-1:0];
            bytes_left <= ByteCntW'(2);
            retry      <= '0;
            tx_d_valid <= 1'b1;
            state      <= StIssue;
          end else if (gnt_rd) begin
            tx_p_data  <= rd_data;
            bytes_left <= ByteCntW'(1);
            retry      <= '0;
            tx_d_valid <= 1'b1;
            state      <= StIssue;
          end
        end
        StIssue: begin
          to_cnt <= '0;
          state  <= StWaitStart;
        end
        StWaitStart: begin
          // Busy takes precedence over a timeout reached in the same cycle.
          if (tx_busy) begin
            state <= StWaitDone;
          end else if (to_cnt + ToCntW'(1) == ToLimit) begin
            to_cnt <= '0;
            if (retry < RetryLimit) begin
              retry      <= retry + RetryCntW'(1);
              tx_d_valid <= 1'b1;
              state      <= StIssue;
            end else begin
              tx_err     <= 1'b1;
              bytes_left <= '0;
              state      <= StIdle;
            end
          end else begin
            to_cnt <= to_cnt + ToCntW'(1);
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (bytes_left == ByteCntW'(2)) begin
              bytes_left <= ByteCntW'(1);
              tx_p_data  <= hold_hi;
              retry      <= '0;
              tx_d_valid <= 1'b1;
              state      <= StIssue;
            end else begin
              bytes_left <= '0;
              state      <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
